// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO.
// Shift-add multiply, restoring divide, one bit per cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state, state_n;

    logic               valid_op;
    logic               div_in;
    logic               sgn_in;
    logic               accept;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               done_q;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_n;
    logic [2*WIDTH-1:0] p_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    always_comb begin
        valid_op = 1'b0;
        div_in   = 1'b0;
        sgn_in   = 1'b0;
        unique case (alucontrol)
            5'b10011: begin
                valid_op = 1'b1;
                sgn_in   = 1'b1;
            end
            5'b10101: valid_op = 1'b1;
            5'b10110: begin
                valid_op = 1'b1;
                div_in   = 1'b1;
                sgn_in   = 1'b1;
            end
            5'b10111: begin
                valid_op = 1'b1;
                div_in   = 1'b1;
            end
            default: ;
        endcase
    end

    assign accept = (state == IDLE) && start && valid_op;
    assign a_neg  = sgn_in & srca[WIDTH-1];
    assign b_neg  = sgn_in & srcb[WIDTH-1];
    assign a_mag  = a_neg ? -srca : srca;
    assign b_mag  = b_neg ? -srcb : srcb;

    assign busy = (state != IDLE);
    assign done = done_q;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept) state_n = RUN;
            RUN:  if (cnt == CW'(WIDTH - 1)) state_n = FIX;
            FIX:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // The partial remainder never exceeds 2*divisor-1, so bit WIDTH
    // of the difference is a reliable borrow flag.
    always_comb begin
        sum     = {1'b0, prod[2*WIDTH-1:WIDTH]}
                + (prod[0] ? {1'b0, opnd} : '0);
        shifted = {rem, prod[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        ge      = ~diff[WIDTH];
        rem_n   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        p_fix   = neg_q ? -prod : prod;
        q_fix   = neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        r_fix   = neg_r ? -rem : rem;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi     <= '0;
            lo     <= '0;
            done_q <= 1'b0;
            opnd   <= '0;
            prod   <= '0;
            rem    <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            done_q <= (state == FIX);
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        opnd   <= div_in ? b_mag : a_mag;
                        prod   <= {{WIDTH{1'b0}},
                                   div_in ? a_mag : b_mag};
                        rem    <= '0;
                        cnt    <= '0;
                        is_div <= div_in;
                        // Divide by zero keeps the all-ones quotient.
                        neg_q  <= (a_neg ^ b_neg)
                                & ~(div_in & (srcb == '0));
                        neg_r  <= a_neg;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        rem              <= rem_n;
                        prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], ge};
                    end else begin
                        prod <= {sum, prod[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (is_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        hi <= p_fix[2*WIDTH-1:WIDTH];
                        lo <= p_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit in the execute stage, directly downstream of the ALU decoder. It consumes the decoder's 5-bit mult/multu/div/divu control codes plus the rs/rt operands, and computes the result over WIDTH+1 cycles while asserting `busy` so the hazard unit can stall dependent mfhi/mflo. The result is written into architectural HI/LO registers, which it also owns (mthi/mtlo writes, mfhi/mflo reads).

## Interface
- `WIDTH`, 32: operand width; also the iteration count.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high.
- `start` input 1: execute-stage instruction valid and targeting this unit.
- `alucontrol` input 5: operation select. Codes: 10011 mult, 10101 multu, 10110 div, 10111 divu. Any other code with `start` is ignored.
- `srca` input WIDTH: rs operand (multiplicand / dividend).
- `srcb` input WIDTH: rt operand (multiplier / divisor).
- `mthi` input 1: write `wdata` into HI.
- `mtlo` input 1: write `wdata` into LO.
- `wdata` input WIDTH: mthi/mtlo data (rs).
- `busy` output 1: operation in flight; combinational from state.
- `done` output 1: one-cycle pulse; HI/LO were updated at the preceding edge.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE: on `start` with a valid code, capture operands and go to RUN.
  - Capture: op, signedness, |srca|, |srcb| (absolute values for signed ops; raw for unsigned), result-sign flags, div-by-zero flag; clear the iteration counter.
- RUN: one iteration per cycle for WIDTH cycles, then go to FIX.
  - Multiply: shift-add on a 2·WIDTH accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring; one quotient bit per cycle, MSB first; partial remainder WIDTH+1 bits.
- FIX: apply sign correction, write HI/LO, go to IDLE, pulse `done`.
  - mult: {HI,LO} = signed 2·WIDTH product, negated if sign(a)^sign(b).
  - multu: {HI,LO} = unsigned product.
  - div: LO = quotient, negated if sign(a)^sign(b); HI = remainder, carrying the sign of srca.
  - divu: LO = quotient, HI = remainder.
  - Overflow, div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0 (falls out of the magnitude path, no special case).
  - Divide by zero (div or divu): LO=0xFFFFFFFF, HI=srca; no sign fix; same latency.
- mthi/mtlo:
  - Take effect at the edge only in IDLE when `start` is not accepted.
  - Ignored while `busy`.
  - If both are set, both registers are written.
- `start` while busy: ignored. The hazard unit guarantees this never happens.
- `start` together with mthi/mtlo in IDLE: start wins; the writes are dropped.
- Reset values:
  - state=IDLE; hi=0, lo=0, busy=0, done=0.
  - Reset mid-operation aborts the operation; HI/LO are cleared to 0 and nothing is written.
- HI/LO hold their value through an entire operation; they update only at the FIX edge.

## Timing
- Edge 0: `start` accepted. `busy`=1 from the cycle after edge 0.
- Edges 1..WIDTH: iterations.
- Edge WIDTH+1: FIX; HI/LO written.
  - During the following cycle: `busy`=0, `done`=1, new hi/lo visible.
- Total: `busy` high for WIDTH+1 cycles (33). Results are readable WIDTH+2 cycles after the start cycle.
- `done` is high exactly one cycle per completed operation and is never asserted for mthi/mtlo.
- A new `start` is accepted in the same cycle `done` is high (back-to-back operations, no bubble).
- `hi`/`lo` are registered outputs; there is no combinational path from inputs to them.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF -> after 33 busy cycles: hi=0xFFFFFFFE, lo=0x00000001, one `done` pulse.
- mult −3 × 7 (0xFFFFFFFD, 0x00000007) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Also mult 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- div −7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100 / 7 -> lo=14, hi=2. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- div and divu 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x1234, same 33-cycle busy window.
- mthi 0xAAAA then mtlo 0x5555 in IDLE -> hi=0xAAAA, lo=0x5555. mtlo during busy -> lo unchanged until FIX. start+mthi same cycle -> mthi dropped.
- reset asserted at iteration 10 of a mult -> next cycle: busy=0, hi=lo=0, no `done`. Back-to-back: second start in the `done` cycle -> second result exactly 34 cycles later.
